// File: rtl/ysyx_22050550_mul_pkg.sv
// ysyx_22050550_mul_pkg: shared FSM states, MulSigned encodings and radix-4 Booth digit decode
package ysyx_22050550_mul_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;
  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_RSV = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_SS = 2'b11;
  typedef enum logic [2:0] {PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2} booth_sel_e;
  function automatic booth_sel_e booth_decode(input logic [2:0] d);
    return (d == 3'b001 || d == 3'b010) ? PP_POS1 :
           (d == 3'b011) ? PP_POS2 :
           (d == 3'b100) ? PP_NEG2 :
           (d == 3'b101 || d == 3'b110) ? PP_NEG1 : PP_ZERO;
  endfunction
endpackage

// File: rtl/ysyx_22050550_booth_pp.sv
// ysyx_22050550_booth_pp: Booth digit {M[1],M[0],pending} to 0/+-A/+-2A partial product
module ysyx_22050550_booth_pp
  import ysyx_22050550_mul_pkg::*;
#(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [2:0]   digit,
  output logic [W-1:0] pp
);
  booth_sel_e sel;
  always_comb begin
    sel = booth_decode(digit);
    pp = sel == PP_POS1 ? a :
         sel == PP_POS2 ? a << 1 :
         sel == PP_NEG1 ? -a :
         sel == PP_NEG2 ? -(a << 1) : '0;
  end
endmodule

// File: rtl/ysyx_22050550_booth_mul.sv
// ysyx_22050550_booth_mul: iterative radix-4 Booth multiplier, one digit per cycle; define YSYX_22050550_MUL_EARLY_EXIT_EN for early exit
module ysyx_22050550_booth_mul
  import ysyx_22050550_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_Exu_MulValid,
  output logic            io_Exu_MulReady,
  input  logic            io_Exu_Flush,
  input  logic            io_Exu_Mulw,
  input  logic [1:0]      io_Exu_MulSigned,
  input  logic [XLEN-1:0] io_Exu_Multiplicand,
  input  logic [XLEN-1:0] io_Exu_Multiplier,
  output logic            io_Exu_OutValid,
  input  logic            io_Exu_OutReady,
  output logic [XLEN-1:0] io_Exu_ResultH,
  output logic [XLEN-1:0] io_Exu_ResultL
);
  localparam int WW = XLEN >= 64 ? 32 : XLEN / 2;
  localparam int CW = $clog2(XLEN / 2 + 2);
  localparam logic [CW-1:0] LAST_F = CW'(XLEN / 2);
  localparam logic [CW-1:0] LAST_W = CW'(WW / 2);
  mul_state_e state, state_n;
  logic [2*XLEN-1:0] a_q, acc_q, pp, a_ext;
  logic [XLEN+1:0] m_q, m_n, m_ext;
  logic p_q, word_q, accept, fin, a_sgn, m_sgn;
  logic [CW-1:0] cnt_q;
  ysyx_22050550_booth_pp #(.W(2 * XLEN)) u_pp (
    .a(a_q),
    .digit({m_q[1:0], p_q}),
    .pp(pp)
  );
  // reserved encoding 01 leaves both operands unsigned
  always_comb begin
    a_sgn = io_Exu_MulSigned[1];
    m_sgn = io_Exu_MulSigned == MUL_SS;
    a_ext = io_Exu_Mulw ? {{(2*XLEN-WW){a_sgn & io_Exu_Multiplicand[WW-1]}}, io_Exu_Multiplicand[WW-1:0]}
                        : {{XLEN{a_sgn & io_Exu_Multiplicand[XLEN-1]}}, io_Exu_Multiplicand};
    m_ext = io_Exu_Mulw ? {{(XLEN+2-WW){m_sgn & io_Exu_Multiplier[WW-1]}}, io_Exu_Multiplier[WW-1:0]}
                        : {{2{m_sgn & io_Exu_Multiplier[XLEN-1]}}, io_Exu_Multiplier};
    m_n = {{2{m_q[XLEN+1]}}, m_q[XLEN+1:2]};
`ifdef YSYX_22050550_MUL_EARLY_EXIT_EN
    fin = cnt_q == (word_q ? LAST_W : LAST_F) || &{m_n, m_q[1]} || ~|{m_n, m_q[1]};
`else
    fin = cnt_q == (word_q ? LAST_W : LAST_F);
`endif
    io_Exu_MulReady = !io_Exu_Flush && (state == S_IDLE || (state == S_DONE && io_Exu_OutReady));
    accept = io_Exu_MulValid && io_Exu_MulReady;
    state_n = io_Exu_Flush ? S_IDLE :
              accept ? S_BUSY :
              (state == S_BUSY && fin) ? S_DONE :
              (state == S_DONE && io_Exu_OutReady) ? S_IDLE : state;
    io_Exu_OutValid = state == S_DONE;
    io_Exu_ResultL = word_q ? {{(XLEN-WW){acc_q[WW-1]}}, acc_q[WW-1:0]} : acc_q[XLEN-1:0];
    io_Exu_ResultH = word_q ? {{(XLEN-WW){acc_q[2*WW-1]}}, acc_q[2*WW-1:WW]} : acc_q[2*XLEN-1:XLEN];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      a_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      p_q <= 1'b0;
      word_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q <= a_ext;
        m_q <= m_ext;
        p_q <= 1'b0;
        acc_q <= '0;
        cnt_q <= '0;
        word_q <= io_Exu_Mulw;
      end else if (state == S_BUSY) begin
        acc_q <= acc_q + pp;
        a_q <= a_q << 2;
        p_q <= m_q[1];
        m_q <= m_n;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050550_booth_mul.sv
// tb_ysyx_22050550_booth_mul: table-driven vectors plus stall, flush and reset sequences
module tb_ysyx_22050550_booth_mul;
  logic clock = 0, reset = 0;
  logic mul_valid = 0, flush = 0, mulw = 0, out_ready = 0;
  logic [1:0] mul_signed = 0;
  logic [63:0] mcand = 0, mplier = 0;
  logic mul_ready, out_valid;
  logic [63:0] res_h, res_l;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic w;
    logic [1:0] s;
    logic [63:0] a, b, h, l;
  } vec_t;
  vec_t vt[15];
  always #5 clock = ~clock;
  ysyx_22050550_booth_mul #(.XLEN(64)) dut (
    .clock(clock),
    .reset(reset),
    .io_Exu_MulValid(mul_valid),
    .io_Exu_MulReady(mul_ready),
    .io_Exu_Flush(flush),
    .io_Exu_Mulw(mulw),
    .io_Exu_MulSigned(mul_signed),
    .io_Exu_Multiplicand(mcand),
    .io_Exu_Multiplier(mplier),
    .io_Exu_OutValid(out_valid),
    .io_Exu_OutReady(out_ready),
    .io_Exu_ResultH(res_h),
    .io_Exu_ResultL(res_l)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask
  task automatic check_lat(input string name, input int lat, input logic w);
    int fixed;
    fixed = w ? 18 : 34;
`ifdef YSYX_22050550_MUL_EARLY_EXIT_EN
    check(name, 64'(lat >= 2 && lat <= fixed), 64'd1);
`else
    check(name, 64'(lat), 64'(fixed));
`endif
  endtask
  task automatic start(input logic w, input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
    mulw = w;
    mul_signed = s;
    mcand = a;
    mplier = b;
    mul_valid = 1;
    @(posedge clock);
    #1;
    mul_valid = 0;
  endtask
  task automatic drain;
    out_ready = 1;
    @(posedge clock);
    #1;
    out_ready = 0;
  endtask
  initial begin
    int lat;
    logic [63:0] hold_h, hold_l;
    logic stable;
    vt[0] = '{0, 2'b00, 64'd3, 64'd5, 64'd0, 64'd15};
    vt[1] = '{0, 2'b11, -64'sd3, 64'd7, '1, 64'hFFFF_FFFF_FFFF_FFEB};
    vt[2] = '{0, 2'b00, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    vt[3] = '{0, 2'b10, '1, 64'd2, '1, 64'hFFFF_FFFF_FFFF_FFFE};
    vt[4] = '{1, 2'b11, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_0000_0002, '1, 64'd0};
    vt[5] = '{0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0};
    vt[6] = '{0, 2'b10, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vt[7] = '{0, 2'b01, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    vt[8] = '{0, 2'b11, '1, '1, 64'd0, 64'd1};
    vt[9] = '{0, 2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64'd0};
    vt[10] = '{1, 2'b00, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    vt[11] = '{1, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'd1};
    vt[12] = '{0, 2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
    vt[13] = '{0, 2'b11, 64'd0, -64'sd5, 64'd0, 64'd0};
    vt[14] = '{0, 2'b00, 64'h1234_5678, 64'h10, 64'd0, 64'h1_2345_6780};
    #2;
    check("reset_ready", 64'(mul_ready), 64'd1);
    check("reset_outvalid", 64'(out_valid), 64'd0);
    check("reset_res_h", res_h, 64'd0);
    check("reset_res_l", res_l, 64'd0);
    #20 reset = 1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 15; i++) begin
      start(vt[i].w, vt[i].s, vt[i].a, vt[i].b);
      wait_out(lat);
      check($sformatf("v%0d_outvalid", i), 64'(out_valid), 64'd1);
      check_lat($sformatf("v%0d_latency", i), lat, vt[i].w);
      check($sformatf("v%0d_res_h", i), res_h, vt[i].h);
      check($sformatf("v%0d_res_l", i), res_l, vt[i].l);
      drain();
      check($sformatf("v%0d_idle_after", i), 64'({out_valid, mul_ready}), 64'b01);
    end
    // stall the result, then hand off with a new request on the same edge
    start(0, 2'b11, -64'sd3, 64'd7);
    wait_out(lat);
    hold_h = res_h;
    hold_l = res_l;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (!out_valid || res_h !== hold_h || res_l !== hold_l) stable = 0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_res_l", res_l, 64'hFFFF_FFFF_FFFF_FFEB);
    check("stall_ready_low", 64'(mul_ready), 64'd0);
    out_ready = 1;
    mulw = 0;
    mul_signed = 2'b00;
    mcand = 64'd3;
    mplier = 64'd5;
    mul_valid = 1;
    #1;
    check("b2b_ready", 64'(mul_ready), 64'd1);
    @(posedge clock);
    #1;
    out_ready = 0;
    mul_valid = 0;
    check("b2b_accepted", 64'({out_valid, mul_ready}), 64'b00);
    wait_out(lat);
`ifdef YSYX_22050550_MUL_EARLY_EXIT_EN
    check("b2b_latency", 64'(lat), 64'd3);
`else
    check("b2b_latency", 64'(lat), 64'd34);
`endif
    check("b2b_res_h", res_h, 64'd0);
    check("b2b_res_l", res_l, 64'd15);
    drain();
    // flush at BUSY cycle 10
    start(0, 2'b00, 64'h1234, 64'h5555_5555_5555_5555);
    repeat (9) @(posedge clock);
    #1;
    flush = 1;
    #1;
    check("flush_ready_low", 64'(mul_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 0;
    #1;
    check("flush_idle", 64'({out_valid, mul_ready}), 64'b01);
    stable = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) stable = 0;
    end
    check("flush_no_out", 64'(stable), 64'd1);
    // flush together with a request: nothing accepted
    flush = 1;
    start(0, 2'b00, 64'd3, 64'd5);
    flush = 0;
    stable = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (out_valid || !mul_ready) stable = 0;
    end
    check("flush_valid_no_accept", 64'(stable), 64'd1);
    // asynchronous reset mid-BUSY
    start(0, 2'b11, -64'sd3, 64'd7);
    repeat (5) @(posedge clock);
    #3;
    reset = 0;
    #1;
    check("rst_mid_ready", 64'(mul_ready), 64'd1);
    check("rst_mid_outvalid", 64'(out_valid), 64'd0);
    check("rst_mid_res_h", res_h, 64'd0);
    check("rst_mid_res_l", res_l, 64'd0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    start(1, 2'b11, 64'h8000_0000, 64'd2);
    wait_out(lat);
    check_lat("post_rst_latency", lat, 1'b1);
    check("post_rst_res_h", res_h, '1);
    check("post_rst_res_l", res_l, 64'd0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22050550_booth_mul.md
# ysyx_22050550_booth_mul

Parametrised iterative radix-4 Booth multiplier for the EXU M-extension path: one 2-bit Booth digit per cycle, XLEN-generic, with full signed/unsigned/mixed modes, word mode and valid/ready on both sides so the EXU can stall the result. It supersedes the fixed-64-bit multiplier and sits between EXU operand issue and EXU writeback.

## Interface
- XLEN, 64: operand width, even, ≥8; product is 2·XLEN.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (reset==0 clears all state immediately).
- io_Exu_MulValid  in  1  request valid.
- io_Exu_MulReady  out  1  request accepted when Valid&&Ready at a clock edge.
- io_Exu_Flush  in  1  abort any operation; highest priority.
- io_Exu_Mulw  in  1  word mode (32-bit operands, RV64 MULW semantics).
- io_Exu_MulSigned  in  2  [1]=multiplicand signed, [0]=multiplier signed (11 MULH, 10 MULHSU, 00 MULHU, 01 reserved→treated as 00).
- io_Exu_Multiplicand, io_Exu_Multiplier  in  XLEN  operands.
- io_Exu_OutValid  out  1  result valid.
- io_Exu_OutReady  in  1  consumer takes result on OutValid&&OutReady.
- io_Exu_ResultH, io_Exu_ResultL  out  XLEN  high/low product halves.

## Operation
- States: IDLE, BUSY, DONE. Reset: state IDLE, all registers 0; MulReady=1, OutValid=0, ResultH/L=0.
- MulReady = IDLE || (DONE && OutReady) — back-to-back accept in the drain cycle; forced 0 when Flush=1.
- Accept latches: A = operand A extended to 2·XLEN (sign per [1]); M = operand B extended to XLEN+2 bits (sign per [0]), implicit bit −1 = 0; ACC=0; iteration count=0. Word mode: operands are bits [31:0], extended per MulSigned, N counts from 32.
- BUSY, one cycle per digit: digit {M[1],M[0],pending}; add 0/±A/±2A to ACC (mod 2^(2·XLEN)); A<<=2; pending=M[1]; M>>=2 arithmetic. N = XLEN/2+1 iterations (33 at 64; 17 in word mode).
- BUSY→DONE after iteration N−1 (or early exit, see Configuration). DONE holds ACC until OutReady.
- Results: full mode ResultH=ACC[2X−1:X], ResultL=ACC[X−1:0]. Word mode ResultL=sext(ACC[31:0]), ResultH=sext(ACC[63:32]).
- Flush: any state → IDLE at next edge, OutValid low, result discarded; Flush and MulValid in same cycle → no accept.
- Unsigned top digit handled by zero-extended two-bit guard in M; no special-case mux.

## Timing
- Accept edge → BUSY; BUSY lasts N cycles (N=33, XLEN=64); OutValid rises the cycle after the last BUSY cycle: accept-to-OutValid 34 cycles full, 18 word.
- OutValid/Result stable while OutReady=0, unbounded.
- New operands accepted on the same edge as result handoff; next OutValid follows same latency.
- Reset asserted mid-operation: outputs return to reset values asynchronously.

## Configuration
- YSYX_22050550_MUL_EARLY_EXIT_EN defined: BUSY→DONE also when, after the current iteration, remaining M and pending bit are all-zero or all-one (remaining digits contribute 0); minimum 1 BUSY cycle. Undefined: always exactly N BUSY cycles (fixed latency). Results identical either way.

## Structure
- Package ysyx_22050550_mul_pkg: state enum, MulSigned encodings, Booth digit→select typedef.
- Sub-module ysyx_22050550_booth_pp: combinational digit decode and ±A/±2A partial-product generation (2·XLEN wide).

## Test plan
- MULHU 3×5, macro off → ResultL=15, ResultH=0, OutValid exactly 34 cycles after accept; macro on → 3 cycles.
- MULH −3×7 → ResultL=0xFFFF_FFFF_FFFF_FFEB, ResultH=0xFFFF_FFFF_FFFF_FFFF.
- MULHU 0xFFFF_FFFF_FFFF_FFFF² → ResultH=0xFFFF_FFFF_FFFF_FFFE, ResultL=1; MULHSU −1×2 → ResultH=all ones, ResultL=0xFFFF_FFFF_FFFF_FFFE.
- MULW signed 0x8000_0000×2 → ResultL=0, ResultH=0xFFFF_FFFF_FFFF_FFFF, latency 18.
- OutReady held 0 for 10 cycles → OutValid/Result constant; on release with MulValid=1 second op accepted same edge, correct result 34 cycles later.
- Flush at BUSY cycle 10 → IDLE next cycle, no OutValid; reset=0 mid-BUSY → MulReady=1, OutValid=0 immediately.
